// File: rtl/fp_result_scoreboard_if.sv
// Expected-vector push channel and fp_unit result channel for fp_result_scoreboard.
interface fp_result_scoreboard_if;
  logic        exp_valid;
  logic        exp_ready;
  logic [31:0] exp_result;
  logic [4:0]  exp_flags;
  logic        exp_nan_chk;
  logic        exp_last;
  logic        dut_ready;
  logic [31:0] dut_result;
  logic [4:0]  dut_flags;

  modport master (
    output exp_valid, exp_result, exp_flags, exp_nan_chk, exp_last,
    output dut_ready, dut_result, dut_flags,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_result, exp_flags, exp_nan_chk, exp_last,
    input  dut_ready, dut_result, dut_flags,
    output exp_ready
  );
endinterface

// File: rtl/fp_result_scoreboard.sv
// Self-check stage behind fp_unit: queues expected result/flag vectors, pops one
// per fp_unit ready pulse, compares with canonical-NaN relaxation, counts
// checks/errors, captures the first mismatch and raises a sticky verdict.
module fp_result_scoreboard #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CNT_W        = 32,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  fp_result_scoreboard_if.slave sb,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 underflow,
  output logic [CNT_W-1:0]     chk_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [31:0]          cap_result_exp,
  output logic [31:0]          cap_result_got,
  output logic [4:0]           cap_flags_exp,
  output logic [4:0]           cap_flags_got
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]       PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [31:0]       CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        nan_chk;
    logic        last;
  } entry_t;

  state_t      state, state_n;
  entry_t      mem [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, active;
  logic        push, pop, uflow_evt;
  logic        is_cmp, is_term, mismatch, mm_evt;
  logic [31:0] rdiff;
  logic [4:0]  fdiff;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign active = (state == S_IDLE) || (state == S_RUN);
  assign head   = mem[rd_ptr[AW-1:0]];

  // exp_ready advertises not-full only; a push that coincides with a pop is
  // still taken when full because the pop frees the slot in the same edge.
  assign sb.exp_ready = active && !full;
  assign pop       = sb.dut_ready && active && !empty;
  assign push      = sb.exp_valid && active && (!full || pop);
  assign uflow_evt = sb.dut_ready && active && empty;

  // Result/flag compare of the FIFO head against fp_unit output, NaN-relaxed
  always_comb begin
    rdiff = head.result ^ sb.dut_result;
    if (head.nan_chk && (sb.dut_result == CANON_NAN)) begin
      rdiff = {1'b0, head.result[30:22] ^ sb.dut_result[30:22], 22'b0};
    end
    fdiff    = head.flags ^ sb.dut_flags;
    mismatch = (rdiff != '0) || (fdiff != '0);
    is_cmp   = pop && !head.last;
    is_term  = pop && head.last;
    mm_evt   = is_cmp && mismatch;
  end

  // Next-state decode; failure outranks terminator, first push/ready leaves IDLE
  always_comb begin
    state_n = state;
    if (active) begin
      if ((uflow_evt || mm_evt) && STOP_ON_FAIL) begin
        state_n = S_FAIL;
      end else if (is_term) begin
        state_n = S_DONE;
      end else if ((state == S_IDLE) && (push || uflow_evt)) begin
        state_n = S_RUN;
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{result:  sb.exp_result,
                               flags:   sb.exp_flags,
                               nan_chk: sb.exp_nan_chk,
                               last:    sb.exp_last};
    end
  end

  // Pointers, counters, capture registers and sticky verdict flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      underflow      <= 1'b0;
      chk_count      <= '0;
      err_count      <= '0;
      cap_result_exp <= '0;
      cap_result_got <= '0;
      cap_flags_exp  <= '0;
      cap_flags_got  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (uflow_evt) begin
        underflow <= 1'b1;
        fail      <= 1'b1;
        if (STOP_ON_FAIL) done <= 1'b1;
      end
      if (is_cmp) begin
        if (chk_count != '1) chk_count <= chk_count + CNT_ONE;
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + CNT_ONE;
          fail <= 1'b1;
          if (STOP_ON_FAIL) done <= 1'b1;
          if (err_count == '0) begin
            cap_result_exp <= head.result;
            cap_result_got <= sb.dut_result;
            cap_flags_exp  <= head.flags;
            cap_flags_got  <= sb.dut_flags;
          end
        end
      end
      if (is_term) begin
        done <= 1'b1;
        pass <= (err_count == '0) && !underflow;
      end
    end
  end

endmodule
